// File: rtl/serial_tx_frame.sv
// Frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit; each bit held CLKS_PER_BIT clocks.
// Latency 1: start bit begins the cycle after accept; in_ready is low for the whole frame and requests are not queued.
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              accept;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign bit_end  = (baud_cnt_q == BAUD_LAST);
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = in_data;
                    parity_d   = ^in_data;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the line changes on the same edge as the state.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule
